clock_sequencer: RTL and testbench

//   Run-control scheduler for the core clock domain. Generates a one-cycle clock-enable

---
 rtl/clock_seq_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 75 +++++++
 rtl/clock_sequencer.sv | 112 +++++++++++
 tb/tb_clock_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_seq_pkg.sv
// Shared state encodings and defaults for the core-clock run-control sequencer.
package clock_seq_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } seq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-(div+1) counter with a pending divider register that is swapped in
// at period boundaries (or immediately while halted), acknowledged by div_ack_o.
module tick_prescaler
    import clock_seq_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             halt_i,
    input  logic             cnt_clr_i,
    input  logic             div_wr_i,
    input  logic [DIV_W-1:0] div_val_i,
    output logic             tick_c_o,
    output logic             div_ack_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             div_ack_q, div_ack_d;
    logic             term_c;
    logic             apply_c;

    // Terminal count and tick are decoded from flops only; no tick while halted.
    assign term_c   = (cnt_q == div_cur_q);
    assign tick_c_o = term_c && !halt_i;
    assign apply_c  = pend_vld_q && (term_c || halt_i);

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        div_ack_d  = 1'b0;

        if (cnt_clr_i || term_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // The older pending value applies first; a same-cycle write stays pending.
        if (apply_c) begin
            div_cur_d  = pend_val_q;
            div_ack_d  = 1'b1;
            pend_vld_d = 1'b0;
        end
        if (div_wr_i) begin
            pend_val_d = div_val_i;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            div_cur_q  <= DIV_W'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_vld_q <= 1'b0;
            div_ack_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            div_ack_q  <= div_ack_d;
        end
    end

    assign div_ack_o = div_ack_q;

endmodule

// File: rtl/clock_sequencer.sv
// Run-control scheduler: core clock-enable strobe, timed core reset release,
// and halt / single-step / resume sequencing on top of tick_prescaler.
module clock_sequencer
    import clock_seq_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 0,
    parameter int unsigned RESET_TICKS = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             tick,
    output logic             resetn,
    output logic             halted
);

    localparam int unsigned TCNT_W = $clog2(RESET_TICKS + 1);

    seq_state_e        state_q, state_d;
    logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              resetn_q, resetn_d;
    logic              halted_q, halted_d;
    logic              tick_c;
    logic              in_halt_c;
    logic              cnt_clr_c;

    // Counter is parked at zero through HALT, including the cycle HALT is entered.
    assign in_halt_c = (state_q == ST_HALT);
    assign cnt_clr_c = in_halt_c || ((state_q == ST_RUN) && halt_req);

    tick_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .halt_i    (in_halt_c),
        .cnt_clr_i (cnt_clr_c),
        .div_wr_i  (div_wr),
        .div_val_i (div_val),
        .tick_c_o  (tick_c),
        .div_ack_o (div_ack)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        resetn_d   = resetn_q;
        halted_d   = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                if (tick_c) begin
                    if (tick_cnt_q != TCNT_W'(RESET_TICKS)) begin
                        tick_cnt_d = tick_cnt_q + TCNT_W'(1);
                    end
                    if (tick_cnt_q == TCNT_W'(RESET_TICKS - 1)) begin
                        state_d  = ST_RUN;
                        resetn_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (tick_c) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_HOLD;
            tick_cnt_q <= '0;
            resetn_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            resetn_q   <= resetn_d;
            halted_q   <= halted_d;
        end
    end

    assign tick   = tick_c;
    assign resetn = resetn_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: fixed vector table, hand-written corner sequences,
// and randomized run-control traffic checked against a behavioural model.
module tb_clock_sequencer;

    localparam int DEF_DIV = 3;
    localparam int RST_TICKS = 4;
    localparam int N_TBL = 53;

    localparam int M_PRE     = 0;
    localparam int M_FREE    = 1;
    localparam int M_STOPPED = 2;
    localparam int M_SINGLE  = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       div_wr = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       halt_req = 1'b0;
    logic       step_req = 1'b0;
    logic       resume_req = 1'b0;
    logic       div_ack;
    logic       tick;
    logic       resetn;
    logic       halted;

    clock_sequencer #(
        .DIV_W       (8),
        .DEFAULT_DIV (DEF_DIV),
        .RESET_TICKS (RST_TICKS)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .div_wr     (div_wr),
        .div_val    (div_val),
        .div_ack    (div_ack),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .resume_req (resume_req),
        .tick       (tick),
        .resetn     (resetn),
        .halted     (halted)
    );

    always #5 CLK = ~CLK;

    // Vector record; exp bits are {tick, resetn, halted, div_ack}.
    typedef struct packed {
        logic       rst;
        logic       dw;
        logic [7:0] dv;
        logic       hr;
        logic       sr;
        logic       rr;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [N_TBL];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nxt = 0;
    logic [3:0] obs;
    logic [3:0] mexp;

    // Behavioural model: mode, position within the current period, divider,
    // pending divider (-1 when none), ticks seen before release.
    int m_mode = M_PRE;
    int m_pos = 0;
    int m_div = DEF_DIV;
    int m_pend = -1;
    int m_seen = 0;
    bit m_rel = 1'b0;
    bit m_ack = 1'b0;

    function automatic logic [3:0] model_out();
        logic t;
        t = (m_mode != M_STOPPED) && (m_pos == m_div);
        return {t, m_rel, (m_mode == M_STOPPED), m_ack};
    endfunction

    task automatic model_adv(input logic rst, dw, input logic [7:0] dv,
                             input logic hr, sr, rr);
        bit t;
        int nmode;
        if (rst) begin
            m_mode = M_PRE;
            m_pos  = 0;
            m_div  = DEF_DIV;
            m_pend = -1;
            m_seen = 0;
            m_rel  = 1'b0;
            m_ack  = 1'b0;
        end else begin
            t = (m_mode != M_STOPPED) && (m_pos == m_div);
            nmode = m_mode;
            m_ack = 1'b0;
            if (m_pend >= 0 && (t || m_mode == M_STOPPED)) begin
                m_div  = m_pend;
                m_pend = -1;
                m_ack  = 1'b1;
            end
            if (dw) m_pend = int'(dv);
            case (m_mode)
                M_PRE: if (t) begin
                    m_seen++;
                    if (m_seen == RST_TICKS) begin
                        nmode = M_FREE;
                        m_rel = 1'b1;
                    end
                end
                M_FREE:    if (hr) nmode = M_STOPPED;
                M_STOPPED: if (rr) nmode = M_FREE; else if (sr) nmode = M_SINGLE;
                default:   if (t) nmode = M_STOPPED;
            endcase
            if (t || nmode == M_STOPPED || m_mode == M_STOPPED) m_pos = 0;
            else m_pos++;
            m_mode = nmode;
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got {tick,resetn,halted,ack}=%b want %b", nm, cyc, act, exp);
        end
    endtask

    // One cycle: sample outputs of the current cycle, then apply this cycle's inputs.
    task automatic drive(input logic rst, dw, input logic [7:0] dv,
                         input logic hr, sr, rr);
        @(negedge CLK);
        cyc  = nxt;
        nxt  = rst ? 0 : nxt + 1;
        obs  = {tick, resetn, halted, div_ack};
        mexp = model_out();
        RESET      = rst;
        div_wr     = dw;
        div_val    = dv;
        halt_req   = hr;
        step_req   = sr;
        resume_req = rr;
        model_adv(rst, dw, dv, hr, sr, rr);
    endtask

    task automatic hs(input string nm, input logic rst, dw, input logic [7:0] dv,
                      input logic hr, sr, rr, input logic [3:0] e);
        drive(rst, dw, dv, hr, sr, rr);
        chk(nm, obs, e);
    endtask

    int tick_list [17] = '{3, 7, 11, 15, 19, 25, 31, 35, 36, 37, 38, 39, 40, 41, 42, 45, 51};
    int halt_list [4]  = '{20, 21, 26, 27};
    int ack_list  [3]  = '{36, 43, 46};

    initial begin
        for (int c = 0; c < N_TBL; c++) begin
            tbl[c] = '0;
            tbl[c].exp[2] = (c >= 16);
        end
        foreach (tick_list[i]) tbl[tick_list[i]].exp[3] = 1'b1;
        foreach (halt_list[i]) tbl[halt_list[i]].exp[1] = 1'b1;
        foreach (ack_list[i])  tbl[ack_list[i]].exp[0]  = 1'b1;
        tbl[19].hr = 1'b1;
        tbl[21].sr = 1'b1;
        tbl[27].rr = 1'b1;
        tbl[32].dw = 1'b1; tbl[32].dv = 8'd1;
        tbl[33].dw = 1'b1; tbl[33].dv = 8'd0;
        tbl[41].dw = 1'b1; tbl[41].dv = 8'd2;
        tbl[42].dw = 1'b1; tbl[42].dv = 8'd5;

        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Release sequence, halt on a tick, single step, resume, divider reloads.
        for (int c = 0; c < N_TBL; c++) begin
            drive(tbl[c].rst, tbl[c].dw, tbl[c].dv, tbl[c].hr, tbl[c].sr, tbl[c].rr);
            chk($sformatf("table%0d", c), obs, tbl[c].exp);
        end

        // Step and resume together: resume wins, period restarts at div=5.
        hs("pre_halt",  1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
        hs("halt_both", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < 5; i++)
            hs("resume_run", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
        hs("resume_tick", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b1100);

        // Reload while halted, then RESET mid-step with a value still pending.
        hs("run_halt2", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
        hs("halt_wr",   1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0110);
        hs("halt_pend", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0110);
        hs("halt_ack",  1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 4'b0111);
        hs("step_rst",  1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
        for (int c = 0; c < 8; c++)
            hs("post_rst", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0,
               (c == 3 || c == 7) ? 4'b1000 : 4'b0000);

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_dw, r_hr, r_sr, r_rr;
            logic [7:0] r_dv;
            r_rst = ($urandom_range(0, 299) == 0);
            r_dw  = ($urandom_range(0, 7) == 0);
            r_dv  = 8'($urandom_range(0, 5));
            r_hr  = ($urandom_range(0, 9) == 0);
            r_sr  = ($urandom_range(0, 5) == 0);
            r_rr  = ($urandom_range(0, 9) == 0);
            drive(r_rst, r_dw, r_dv, r_hr, r_sr, r_rr);
            chk("model", obs, mexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
